// File: rtl/tdm_demux4.sv
// tdm_demux4: receive side of an N_CH-slot TDM link.
// Locks to the slot-0 sync marker, gathers one sample per slot into shadow
// registers and publishes the completed frame on y with a one-clock
// frame_valid pulse. Framing violations drop the partial frame and pulse
// sync_err.
module tdm_demux4 #(
    parameter int N_CH = 4
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       din,
    input  logic                       sync,
    input  logic                       en,
    output logic [N_CH-1:0]            y,
    output logic [$clog2(N_CH)-1:0]    sel,
    output logic                       frame_valid,
    output logic                       locked,
    output logic                       sync_err
);

    localparam int SEL_W = $clog2(N_CH);

    typedef enum logic {
        HUNT   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    // The last slot is never stored: it goes straight from din into y on
    // the edge that completes the frame, so only N_CH-1 shadow bits exist.
    state_t            state_q, state_d;
    logic [SEL_W-1:0]  sel_q, sel_d;
    logic [N_CH-2:0]   shadow_q, shadow_d;
    logic [N_CH-1:0]   y_q, y_d;
    logic              frame_valid_q, frame_valid_d;
    logic              sync_err_q, sync_err_d;

    // Framing state machine: next state, slot index, shadow writes and the
    // one-cycle pulses, all evaluated only on enabled samples.
    always_comb begin
        state_d       = state_q;
        sel_d         = sel_q;
        shadow_d      = shadow_q;
        y_d           = y_q;
        frame_valid_d = 1'b0;
        sync_err_d    = 1'b0;

        if (en) begin
            unique case (state_q)
                HUNT: begin
                    if (sync) begin
                        shadow_d[0] = din;
                        sel_d       = SEL_W'(1);
                        state_d     = LOCKED;
                    end
                end
                LOCKED: begin
                    if (sync) begin
                        // A sync anywhere but slot 0 restarts the frame here;
                        // the half-built frame is abandoned without touching y.
                        if (sel_q != '0) begin
                            sync_err_d = 1'b1;
                        end
                        shadow_d[0] = din;
                        sel_d       = SEL_W'(1);
                    end else if (sel_q == '0) begin
                        // Slot 0 arrived without its marker: lost framing.
                        sync_err_d = 1'b1;
                        state_d    = HUNT;
                    end else if (sel_q == SEL_W'(N_CH - 1)) begin
                        y_d           = {din, shadow_q};
                        frame_valid_d = 1'b1;
                        sel_d         = '0;
                    end else begin
                        for (int k = 1; k < N_CH - 1; k++) begin
                            if (sel_q == SEL_W'(k)) begin
                                shadow_d[k] = din;
                            end
                        end
                        sel_d = sel_q + SEL_W'(1);
                    end
                end
                default: begin
                    state_d = HUNT;
                end
            endcase
        end
    end

    // State register with synchronous active-low reset clearing everything.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q       <= HUNT;
            sel_q         <= '0;
            shadow_q      <= '0;
            y_q           <= '0;
            frame_valid_q <= 1'b0;
            sync_err_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            sel_q         <= sel_d;
            shadow_q      <= shadow_d;
            y_q           <= y_d;
            frame_valid_q <= frame_valid_d;
            sync_err_q    <= sync_err_d;
        end
    end

    assign y           = y_q;
    assign sel         = sel_q;
    assign frame_valid = frame_valid_q;
    assign sync_err    = sync_err_q;
    assign locked      = (state_q == LOCKED);

endmodule

// File: tb/tb_tdm_demux4.sv
// Testbench for tdm_demux4: directed scenarios followed by random traffic,
// every cycle compared against a queue-based frame model.
module tb_tdm_demux4;

    localparam int N = 4;

    logic         clk;
    logic         reset_n;
    logic         din;
    logic         sync;
    logic         en;
    logic [N-1:0] y;
    logic [1:0]   sel;
    logic         frame_valid;
    logic         locked;
    logic         sync_err;

    int total = 0;
    int bad   = 0;
    int step  = 0;

    // Reference model state: collected samples of the current frame.
    bit           m_locked;
    bit           m_frame[$];
    logic [N-1:0] m_y;
    bit           m_fv;
    bit           m_err;

    tdm_demux4 #(.N_CH(N)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .din         (din),
        .sync        (sync),
        .en          (en),
        .y           (y),
        .sel         (sel),
        .frame_valid (frame_valid),
        .locked      (locked),
        .sync_err    (sync_err)
    );

    // Free-running clock, 10 time units per period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Single comparison point; counts and reports mismatches.
    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s step=%0d got=%0h exp=%0h", tag, step, got, exp);
        end
    endtask

    // Frame-level model of one clock edge.
    task automatic modelStep(input bit r, input bit e, input bit s, input bit d);
        m_fv  = 0;
        m_err = 0;
        if (!r) begin
            m_locked = 0;
            m_frame.delete();
            m_y = '0;
        end else if (e) begin
            if (!m_locked) begin
                if (s) begin
                    m_frame.delete();
                    m_frame.push_back(d);
                    m_locked = 1;
                end
            end else if (s) begin
                if (m_frame.size() != 0) m_err = 1;
                m_frame.delete();
                m_frame.push_back(d);
            end else if (m_frame.size() == 0) begin
                m_err    = 1;
                m_locked = 0;
            end else begin
                m_frame.push_back(d);
                if (m_frame.size() == N) begin
                    for (int k = 0; k < N; k++) m_y[k] = m_frame[k];
                    m_fv = 1;
                    m_frame.delete();
                end
            end
        end
    endtask

    task automatic compareAll();
        checkOutput("y", 32'(y), 32'(m_y));
        checkOutput("sel", 32'(sel), 32'(m_frame.size()));
        checkOutput("frame_valid", 32'(frame_valid), 32'(m_fv));
        checkOutput("locked", 32'(locked), 32'(m_locked));
        checkOutput("sync_err", 32'(sync_err), 32'(m_err));
        checkOutput("pulse_excl", 32'(frame_valid & sync_err), 32'(0));
    endtask

    // Drive one cycle of inputs on the falling edge, then check after the rise.
    task automatic applyStimulus(input bit r, input bit e, input bit s, input bit d);
        @(negedge clk);
        reset_n = r;
        en      = e;
        sync    = s;
        din     = d;
        @(posedge clk);
        modelStep(r, e, s, d);
        step++;
        #1;
        compareAll();
    endtask

    // Send one full aligned frame; bits[k] is the slot-k sample.
    task automatic sendFrame(input logic [N-1:0] bits);
        for (int k = 0; k < N; k++) applyStimulus(1, 1, (k == 0), bits[k]);
    endtask

    initial begin
        reset_n = 1'b0;
        en      = 1'b0;
        sync    = 1'b0;
        din     = 1'b0;
        m_locked = 0;
        m_y      = '0;
        m_fv     = 0;
        m_err    = 0;

        // 1: reset, then continuous frame 1,0,0,0
        applyStimulus(0, 0, 0, 0);
        applyStimulus(0, 1, 1, 1);
        checkOutput("rst_y", 32'(y), 32'(0));
        checkOutput("rst_locked", 32'(locked), 32'(0));
        sendFrame(4'b0001);
        checkOutput("s1_y", 32'(y), 32'h1);
        checkOutput("s1_fv", 32'(frame_valid), 32'(1));
        checkOutput("s1_locked", 32'(locked), 32'(1));
        checkOutput("s1_sel", 32'(sel), 32'(0));
        applyStimulus(1, 0, 0, 1);
        checkOutput("s1_fv_off", 32'(frame_valid), 32'(0));

        // 2: en on alternate cycles, din 0,1,1,0
        for (int k = 0; k < N; k++) begin
            applyStimulus(1, 1, (k == 0), (k == 1 || k == 2));
            if (k != N - 1) begin
                applyStimulus(1, 0, 1, 1);
                checkOutput("s2_hold_y", 32'(y), 32'h1);
            end
        end
        checkOutput("s2_y", 32'(y), 32'h6);
        checkOutput("s2_fv", 32'(frame_valid), 32'(1));
        applyStimulus(1, 0, 0, 0);
        checkOutput("s2_fv_off", 32'(frame_valid), 32'(0));

        // 3: missing sync at slot 0, then relock with 1,1,1,1
        applyStimulus(1, 1, 0, 1);
        checkOutput("s3_err", 32'(sync_err), 32'(1));
        checkOutput("s3_locked", 32'(locked), 32'(0));
        checkOutput("s3_y", 32'(y), 32'h6);
        sendFrame(4'b1111);
        checkOutput("s3_y_relock", 32'(y), 32'hF);

        // 4: early sync at sel=2, restart sample 1 then 0,1,0
        applyStimulus(1, 1, 1, 0);
        applyStimulus(1, 1, 0, 0);
        applyStimulus(1, 1, 1, 1);
        checkOutput("s4_err", 32'(sync_err), 32'(1));
        checkOutput("s4_fv", 32'(frame_valid), 32'(0));
        checkOutput("s4_sel", 32'(sel), 32'(1));
        applyStimulus(1, 1, 0, 0);
        applyStimulus(1, 1, 0, 1);
        applyStimulus(1, 1, 0, 0);
        checkOutput("s4_y", 32'(y), 32'h5);

        // 5: reset, then 10 unsynced samples in HUNT
        applyStimulus(0, 0, 0, 0);
        for (int k = 0; k < 10; k++) begin
            applyStimulus(1, 1, 0, k[0]);
            checkOutput("s5_quiet", 32'({sync_err, frame_valid, locked, sel, y}), 32'(0));
        end

        // 6: y=1010, fill to sel=3, glitch reset between edges, then reset
        sendFrame(4'b1010);
        checkOutput("s6_y", 32'(y), 32'hA);
        for (int k = 0; k < N - 1; k++) applyStimulus(1, 1, (k == 0), 1);
        @(negedge clk);
        en      = 1'b0;
        reset_n = 1'b0;
        #2 reset_n = 1'b1;
        @(posedge clk);
        modelStep(1, 0, 0, 0);
        step++;
        #1;
        compareAll();
        checkOutput("s6_glitch_sel", 32'(sel), 32'(3));
        applyStimulus(0, 1, 0, 1);
        checkOutput("s6_rst", 32'({frame_valid, locked, sel, y}), 32'(0));

        // Random traffic: mostly aligned sync with occasional errors and resets.
        for (int i = 0; i < 3000; i++) begin
            bit r, e, s, d;
            int p;
            p = int'($urandom % 100);
            r = ($urandom % 250) != 0;
            e = ($urandom % 3) != 0;
            s = (m_frame.size() == 0) ^ (p < 7);
            d = 1'($urandom);
            applyStimulus(r, e, s, d);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
